// File: rtl/keccak_arb_pkg.sv
// Shared types and widths for the two-requester Keccak core arbiter.
package keccak_arb_pkg;

    localparam int IN_W  = 192;
    localparam int BN_W  = 6;
    localparam int OUT_W = 512;
    localparam int NREQ  = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FEED,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. "last" is one-hot of the previously served
// requester; 2'b00 (nobody served yet) favours requester 0.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt,
    output logic       any
);

    // On contention hand the core to whoever was not served last.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last[0] ? 2'b10 : 2'b01;
        end
    end

    assign any = |req;

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one Keccak core between two requesters: arbitrates, clears the
// core, forwards the owner's words and captures the digest.
//
// state | meaning
// IDLE  | no owner, arbitrate pending requests
// CLR   | one-cycle core clear, owner already granted
// FEED  | owner's words forwarded to the core
// WAIT  | last word accepted, waiting for core_out_ready
// DONE  | one-cycle done pulse to the owner, digest valid
module keccak_arbiter
    import keccak_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,

    input  logic             rq0_req,
    input  logic [IN_W-1:0]  rq0_in,
    input  logic             rq0_in_ready,
    input  logic             rq0_is_last,
    input  logic [BN_W-1:0]  rq0_byte_num,
    output logic             rq0_buffer_full,
    output logic             rq0_grant,
    output logic             rq0_done,

    input  logic             rq1_req,
    input  logic [IN_W-1:0]  rq1_in,
    input  logic             rq1_in_ready,
    input  logic             rq1_is_last,
    input  logic [BN_W-1:0]  rq1_byte_num,
    output logic             rq1_buffer_full,
    output logic             rq1_grant,
    output logic             rq1_done,

    output logic [OUT_W-1:0] digest,

    output logic             core_reset,
    output logic [IN_W-1:0]  core_in,
    output logic             core_in_ready,
    output logic             core_is_last,
    output logic [BN_W-1:0]  core_byte_num,
    input  logic             core_buffer_full,
    input  logic             core_out_ready,
    input  logic [OUT_W-1:0] core_out
);

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic [1:0]        last_gnt;
    logic [1:0]        gnt;
    logic              any;

    logic              owner_req;
    logic [IN_W-1:0]   own_in;
    logic              own_in_ready;
    logic              own_is_last;
    logic [BN_W-1:0]   own_byte_num;
    logic              accept;
    logic              abort;
    logic              finish;

    rr_pick2 u_pick (
        .req  ({rq1_req, rq0_req}),
        .last (last_gnt),
        .gnt  (gnt),
        .any  (any)
    );

    assign owner_req    = owner ? rq1_req      : rq0_req;
    assign own_in       = owner ? rq1_in       : rq0_in;
    assign own_in_ready = owner ? rq1_in_ready : rq0_in_ready;
    assign own_is_last  = owner ? rq1_is_last  : rq0_is_last;
    assign own_byte_num = owner ? rq1_byte_num : rq0_byte_num;

    assign accept = (state == FEED) && own_in_ready && !core_buffer_full;
    assign abort  = (state inside {CLR, FEED, WAIT}) && !owner_req;
    // Both a completed hash and an abort count as the owner having been served.
    assign finish = (state == DONE) || abort;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; an owner dropping its request wins over progress.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any) state_nxt = CLR;
            CLR:  state_nxt = owner_req ? FEED : IDLE;
            FEED: begin
                if (!owner_req)                state_nxt = IDLE;
                else if (accept && own_is_last) state_nxt = WAIT;
            end
            WAIT: begin
                if (!owner_req)          state_nxt = IDLE;
                else if (core_out_ready) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner capture, round-robin history and digest capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= 1'b0;
            last_gnt <= 2'b00;
            digest   <= '0;
        end else begin
            if (state == IDLE && any) owner <= (gnt == 2'b10);
            if (finish) last_gnt <= owner ? 2'b10 : 2'b01;
            if (state == WAIT && owner_req && core_out_ready) digest <= core_out;
        end
    end

    // Output decode: owner mux towards the core, per-requester status back.
    always_comb begin
        core_in         = own_in;
        core_is_last    = own_is_last;
        core_byte_num   = own_byte_num;
        core_in_ready   = (state == FEED) && own_in_ready;
        core_reset      = reset || (state == CLR);
        rq0_grant       = (state != IDLE) && !owner;
        rq1_grant       = (state != IDLE) &&  owner;
        rq0_done        = (state == DONE) && !owner;
        rq1_done        = (state == DONE) &&  owner;
        rq0_buffer_full = !((state == FEED) && !owner) || core_buffer_full;
        rq1_buffer_full = !((state == FEED) &&  owner) || core_buffer_full;
    end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Bench for keccak_arbiter: cycle table, directed corner sequences and a
// randomized run against a transaction-level ownership model.
module tb_keccak_arbiter;

    localparam logic [191:0] MSG  = 192'h90ABCDEF1a1b1c1d90ABCDEF1a1b1c1d90ABCDEF1a1b1c1d;
    localparam logic [511:0] GOLD = 512'h4ec801ad18daa74c1139259ec8b382e5a490dbe85fcedf81274557e1233a71c508397e467cae022488a3455e0acef98470300b6488154c8821011b959a6c611e;
    localparam int P_CLR = 0, P_FEED = 1, P_WAIT = 2, P_DONE = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req, ir, il;
    logic [191:0] din [2];
    logic [5:0]   bn [2];
    logic         cbf, cor;
    logic [511:0] cout;

    wire  [1:0]   bfull, grant, done;
    wire  [511:0] digest;
    wire          crst, cir, cil;
    wire  [191:0] cin;
    wire  [5:0]   cbn;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0] req, ir, il;
        logic       cbf, cor;
        logic [1:0] e_gnt, e_done;
        logic       e_crst, e_cir;
        logic [1:0] e_bf;
        logic       e_gold;
    } vec_t;
    vec_t tbl [15];

    // reference model: who owns the core, where in the transaction it is
    bit           m_busy;
    int           m_own, m_ph, m_pref;
    logic [511:0] m_dig;
    logic [1:0]   e_gnt, e_done, e_bf, drop;
    logic         e_crst, e_cir;
    logic [511:0] saved;

    keccak_arbiter dut (
        .clk(clk), .reset(reset),
        .rq0_req(req[0]), .rq0_in(din[0]), .rq0_in_ready(ir[0]), .rq0_is_last(il[0]),
        .rq0_byte_num(bn[0]), .rq0_buffer_full(bfull[0]), .rq0_grant(grant[0]), .rq0_done(done[0]),
        .rq1_req(req[1]), .rq1_in(din[1]), .rq1_in_ready(ir[1]), .rq1_is_last(il[1]),
        .rq1_byte_num(bn[1]), .rq1_buffer_full(bfull[1]), .rq1_grant(grant[1]), .rq1_done(done[1]),
        .digest(digest),
        .core_reset(crst), .core_in(cin), .core_in_ready(cir), .core_is_last(cil),
        .core_byte_num(cbn), .core_buffer_full(cbf), .core_out_ready(cor), .core_out(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req = 2'b00; ir = 2'b00; il = 2'b00; cbf = 1'b0; cor = 1'b0;
        din[0] = MSG; din[1] = MSG; bn[0] = 6'd23; bn[1] = 6'd23; cout = GOLD;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (!m_busy) begin
            if (req != 2'b00) begin
                m_own  = (req == 2'b11) ? m_pref : (req[0] ? 0 : 1);
                m_busy = 1;
                m_ph   = P_CLR;
            end
        end else if (m_ph != P_DONE && !req[m_own]) begin
            m_busy = 0;
            m_pref = 1 - m_own;
        end else begin
            case (m_ph)
                P_CLR:  m_ph = P_FEED;
                P_FEED: if (ir[m_own] && !cbf && il[m_own]) m_ph = P_WAIT;
                P_WAIT: if (cor) begin m_dig = cout; m_ph = P_DONE; end
                default: begin m_busy = 0; m_pref = 1 - m_own; end
            endcase
        end
    endtask

    task automatic model_expect();
        e_gnt = 2'b00; e_done = 2'b00; e_bf = 2'b11;
        e_crst = m_busy && m_ph == P_CLR;
        e_cir = 1'b0;
        if (m_busy) begin
            e_gnt[m_own] = 1'b1;
            if (m_ph == P_DONE) e_done[m_own] = 1'b1;
            if (m_ph == P_FEED) begin
                e_bf[m_own] = cbf;
                e_cir = ir[m_own];
            end
        end
    endtask

    initial begin
        quiet();
        do_reset();

        // reset state
        chk("rst_grant", 512'(grant), 512'(2'b00));
        chk("rst_done", 512'(done), 512'(2'b00));
        chk("rst_bfull", 512'(bfull), 512'(2'b11));
        chk("rst_cir", 512'(cir), 512'(1'b0));
        chk("rst_digest", digest, 512'd0);

        // req, ir, il, cbf, cor | gnt, done, crst, cir, bf, gold
        tbl[0]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0};
        tbl[1]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0};
        tbl[2]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0};
        tbl[3]  = '{2'b11, 2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b11, 1'b0};
        tbl[4]  = '{2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0};
        tbl[5]  = '{2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0};
        tbl[6]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0};
        tbl[7]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 2'b11, 1'b1};
        tbl[8]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1};
        tbl[9]  = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1};
        tbl[10] = '{2'b10, 2'b11, 2'b11, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1};
        tbl[11] = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1};
        tbl[12] = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1};
        tbl[13] = '{2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 1'b1};
        tbl[14] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1};

        foreach (tbl[i]) begin
            req = tbl[i].req; ir = tbl[i].ir; il = tbl[i].il;
            cbf = tbl[i].cbf; cor = tbl[i].cor;
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", i), 512'(grant), 512'(tbl[i].e_gnt));
            chk($sformatf("tbl%0d_done", i), 512'(done), 512'(tbl[i].e_done));
            chk($sformatf("tbl%0d_crst", i), 512'(crst), 512'(tbl[i].e_crst));
            chk($sformatf("tbl%0d_cir", i), 512'(cir), 512'(tbl[i].e_cir));
            chk($sformatf("tbl%0d_bfull", i), 512'(bfull), 512'(tbl[i].e_bf));
            chk($sformatf("tbl%0d_digest", i), digest, tbl[i].e_gold ? GOLD : 512'd0);
            if (tbl[i].e_cir) begin
                chk($sformatf("tbl%0d_cin", i), 512'(cin), 512'(MSG));
                chk($sformatf("tbl%0d_cbn", i), 512'(cbn), 512'(6'd23));
            end
            adv();
        end

        // abort: rq1 drops req in WAIT while rq0 waits; out_ready same cycle
        quiet();
        req = 2'b10; adv();                 // IDLE -> CLR
        adv();                              // CLR -> FEED
        ir = 2'b10; il = 2'b10; adv();      // last word accepted -> WAIT
        ir = 2'b00; il = 2'b00; req = 2'b11;
        @(negedge clk);
        chk("abort_wait_grant", 512'(grant), 512'(2'b10));
        adv();
        req = 2'b01; cor = 1'b1; cout = ~GOLD;
        adv();
        cor = 1'b0;
        @(negedge clk);
        chk("abort_idle_grant", 512'(grant), 512'(2'b00));
        chk("abort_no_done", 512'(done), 512'(2'b00));
        chk("abort_digest", digest, GOLD);
        adv();
        @(negedge clk);
        chk("abort_rq0_next", 512'(grant), 512'(2'b01));
        chk("abort_rq0_crst", 512'(crst), 512'(1'b1));
        adv();

        // back-pressure in FEED, then stray out_ready in FEED
        ir = 2'b01; il = 2'b01; cbf = 1'b1; cor = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_cir", k), 512'(cir), 512'(1'b1));
            chk($sformatf("bp%0d_bfull", k), 512'(bfull), 512'(2'b11));
            chk($sformatf("bp%0d_grant", k), 512'(grant), 512'(2'b01));
            chk($sformatf("bp%0d_digest", k), digest, GOLD);
            chk($sformatf("bp%0d_done", k), 512'(done), 512'(2'b00));
            adv();
        end
        cbf = 1'b0; cor = 1'b0;
        @(negedge clk);
        chk("bp_release_bfull", 512'(bfull), 512'(2'b10));
        adv();
        @(negedge clk);
        chk("bp_wait_cir", 512'(cir), 512'(1'b0));
        chk("bp_wait_grant", 512'(grant), 512'(2'b01));
        quiet();                            // abort back to IDLE
        adv();
        cor = 1'b1; cout = ~GOLD;           // stray out_ready in IDLE
        @(negedge clk);
        chk("stray_idle_done", 512'(done), 512'(2'b00));
        adv();
        @(negedge clk);
        chk("stray_idle_digest", digest, GOLD);
        cor = 1'b0; cout = GOLD;

        // reset mid-FEED of a multi-word message
        adv();
        req = 2'b01; adv(); adv();
        ir = 2'b01; il = 2'b00; adv();      // non-last word accepted
        @(negedge clk);
        chk("mid_feed_grant", 512'(grant), 512'(2'b01));
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_grant", 512'(grant), 512'(2'b00));
        chk("rst_mid_crst", 512'(crst), 512'(1'b1));
        chk("rst_mid_cir", 512'(cir), 512'(1'b0));
        chk("rst_mid_bfull", 512'(bfull), 512'(2'b11));
        chk("rst_mid_digest", digest, 512'd0);
        ir = 2'b00;
        adv();
        reset = 1'b0;
        adv();                              // IDLE -> CLR
        adv();                              // CLR -> FEED
        ir = 2'b01; il = 2'b01; adv();      // -> WAIT
        ir = 2'b00; il = 2'b00; cor = 1'b1; adv();
        cor = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 512'(done), 512'(2'b01));
        chk("post_rst_digest", digest, GOLD);
        adv();

        // randomized run against the model
        do_reset();
        m_busy = 0; m_own = 0; m_ph = P_CLR; m_pref = 0; m_dig = '0; drop = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (drop[n]) req[n] = 1'b0;
                else if (!req[n]) req[n] = ($urandom_range(3) == 0);
                else if ($urandom_range(29) == 0) req[n] = 1'b0;
                ir[n] = $urandom_range(1) == 1;
                il[n] = $urandom_range(2) == 0;
                bn[n] = 6'($urandom_range(24));
                for (int k = 0; k < 6; k++) din[n][k*32 +: 32] = $urandom();
            end
            drop = 2'b00;
            cbf = $urandom_range(2) == 0;
            cor = $urandom_range(3) == 0;
            for (int k = 0; k < 16; k++) cout[k*32 +: 32] = $urandom();
            @(negedge clk);
            model_expect();
            chk("rnd_grant", 512'(grant), 512'(e_gnt));
            chk("rnd_done", 512'(done), 512'(e_done));
            chk("rnd_crst", 512'(crst), 512'(e_crst));
            chk("rnd_cir", 512'(cir), 512'(e_cir));
            chk("rnd_bfull", 512'(bfull), 512'(e_bf));
            chk("rnd_digest", digest, m_dig);
            if (e_cir) begin
                chk("rnd_cin", 512'(cin), 512'(din[m_own]));
                chk("rnd_cil", 512'(cil), 512'(il[m_own]));
                chk("rnd_cbn", 512'(cbn), 512'(bn[m_own]));
            end
            for (int n = 0; n < 2; n++)
                if (e_done[n] && $urandom_range(3) != 0) drop[n] = 1'b1;
            model_step();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keccak_arbiter.md
KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 For each requester n in {0,1}: rqn_req  input  1  requester n holds this high to request the core until it sees rqn_done.
REQ-004 For each n: rqn_in  input  192  message word.
REQ-005 For each n: rqn_in_ready  input  1  word valid.
REQ-006 For each n: rqn_is_last  input  1  final word of the message.
REQ-007 For each n: rqn_byte_num  input  6  valid bytes in the final word, 0..24.
REQ-008 For each n: rqn_buffer_full  output  1  back-pressure to requester n.
REQ-009 For each n: rqn_grant  output  1  requester n owns the core.
REQ-010 For each n: rqn_done  output  1  one-cycle pulse; digest is valid.
REQ-011 digest  output  512  last completed hash, held stable until the next DONE.
REQ-012 Core side: core_reset, core_in[191:0], core_in_ready, core_is_last, core_byte_num[5:0] are outputs; core_buffer_full and core_out_ready are 1-bit inputs; core_out[511:0] is a 512-bit input.

Function
REQ-013 The FSM SHALL have states IDLE, CLR, FEED, WAIT and DONE.
REQ-014 IDLE: with at least one rqn_req high, the arbiter SHALL pick the winner round-robin and go to CLR on the next edge.
- On simultaneous requests, the winner is the requester not granted last.
- After reset, requester 0 has priority.
REQ-015 CLR SHALL last exactly 1 cycle.
- core_reset=1 in CLR.
- Owner's grant asserts on entry to CLR; FEED follows.
REQ-016 FEED: core_in, core_in_ready, core_is_last and core_byte_num SHALL be the owner's signals, combinationally muxed.
- The non-owner's inputs SHALL be ignored, and core_in_ready SHALL be gated to 0 for it.
REQ-017 The owner's rqn_buffer_full SHALL equal core_buffer_full in FEED and SHALL be 1 in every other state.
- The non-owner's rqn_buffer_full SHALL be 1 at all times.
REQ-018 A word is accepted when, in FEED, owner in_ready=1 and core_buffer_full=0.
- Acceptance with is_last=1 SHALL move the FSM to WAIT.
- Words offered while buffer_full=1 are not accepted, and the owner SHALL hold them.
REQ-019 WAIT: core_in_ready=0.
- On core_out_ready=1, the arbiter SHALL latch core_out into digest and go to DONE.
REQ-020 DONE SHALL last 1 cycle.
- rqn_done=1 for the owner only.
- DONE then goes to IDLE, the grant drops, and the round-robin pointer updates to this owner.
REQ-021 If the owner drops rqn_req in CLR, FEED or WAIT (abort), the FSM SHALL go to IDLE on the next edge without a done pulse.
- digest SHALL be left unchanged.
- The round-robin pointer SHALL still update.
REQ-022 core_out_ready=1 outside WAIT SHALL be ignored.
REQ-023 Latency: req rising in IDLE SHALL give grant 1 cycle later, with the first word acceptable in the cycle after CLR.
- out_ready in WAIT SHALL give done plus digest 1 cycle later.
REQ-024 A requester whose req is still high in DONE's following IDLE SHALL be rearbitrated normally, with no back-to-back grant if the other requests.

Reset
REQ-025 Asserting reset SHALL asynchronously force the FSM to IDLE and the round-robin pointer to 0.
- Outputs on reset: grants 0, dones 0, digest 0, rqn_buffer_full 1, core_in_ready 0.
REQ-026 core_reset SHALL equal reset OR (state==CLR).
- Reset mid-message therefore also clears the core.

Structure
REQ-027 Shared package keccak_arb_pkg SHALL hold the state enum and the constants IN_W=192, BN_W=6, OUT_W=512 and NREQ=2.
REQ-028 Round-robin selection SHALL be one sub-module rr_pick2, with inputs req[1:0] and last, and outputs gnt[1:0] and any.
- Everything else is flat.

Verification
REQ-029 Single message: rq0 sends 192'h90ABCDEF1a1b1c1d90ABCDEF1a1b1c1d90ABCDEF1a1b1c1d, byte_num=23, is_last=1.
- Required: rq0_done pulses once and digest=512'h4ec801ad18daa74c1139259ec8b382e5a490dbe85fcedf81274557e1233a71c508397e467cae022488a3455e0acef98470300b6488154c8821011b959a6c611e.
- Required: core_reset high for exactly 1 cycle before the first word.
REQ-030 Contention: rq0 and rq1 raise req in the same cycle after reset, both sending the vector above.
- Required: rq0 is granted first, then rq1, with two done pulses and no overlapping grants.
REQ-031 Back-pressure: the owner offers words while core_buffer_full=1.
- Required: core_in_ready stays asserted, no word is accepted, the FSM stays in FEED, and the word is accepted on the first cycle buffer_full=0.
REQ-032 Abort: rq1 drops req in WAIT.
- Required: IDLE next cycle, no rq1_done, digest unchanged, and a pending rq0 is granted next.
REQ-033 Reset mid-FEED: reset pulsed during a multi-word message.
- Required: immediate IDLE, grants 0, core_reset high, and a subsequent rq0 message yields the golden digest.
REQ-034 Stray core_out_ready in IDLE or FEED SHALL cause no done and no digest change.
